// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the lock-in modulation path.
//   HPW / PHW      : widths of the generator's period divider and phase offset
//   sched_state_e  : state encoding of the hp/phase update scheduler
// -----------------------------------------------------------------------------
package lock_pkg;

  localparam int HPW = 14;
  localparam int PHW = 13;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_PEND  = 2'd1,
    SCHED_SWEEP = 2'd2
  } sched_state_e;

endpackage : lock_pkg

// File: rtl/sched_watchdog.sv
// -----------------------------------------------------------------------------
// sched_watchdog
// Loadable down-counter used to bound how long a staged update may wait for a
// period boundary. The count saturates at zero; expired is high while enabled
// and the count has reached zero.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over clr and counting)
//   load_val  : value loaded; expiry follows load_val+1 enabled clocks later
//   clr       : force the count to zero
//   en        : count down one per clock
//   expired   : count is zero while enabled
// -----------------------------------------------------------------------------
module sched_watchdog #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule : sched_watchdog

// File: rtl/gen_mod_sched.sv
// -----------------------------------------------------------------------------
// gen_mod_sched
// Update scheduler and sweep sequencer for the harmonic modulation generator.
// Register-bus writes of hp/phase are staged and committed only on a waveform
// period boundary (harmonic_trig) so the generator never glitches mid-period.
// In sweep mode hp steps between sweep_hp_min and sweep_hp_max, one step every
// sweep_dwell+1 periods.
//
// Build option: GEN_MOD_SCHED_TIMEOUT_EN
//   defined   : a watchdog forces the commit after TIMEOUT clocks without a
//               trig, pulsing gen_rst alongside upd_done.
//   undefined : PEND waits for harmonic_trig indefinitely; gen_rst is 0.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cfg_hp, cfg_phase, cfg_wr   staged values and their single-cycle strobe
//   sweep_en                    enable autonomous hp sweep
//   sweep_hp_min/max            inclusive sweep limits
//   sweep_step                  hp increment per step
//   sweep_dwell                 periods per step minus 1
//   harmonic_trig               period-boundary pulse from the generator
//   hp, phase                   committed values (registered)
//   busy                        staged update pending
//   upd_done                    one-cycle pulse per commit
//   sweep_wrap                  one-cycle pulse when the sweep returns to min
//   gen_rst                     one-cycle generator resync on a forced commit
// -----------------------------------------------------------------------------
module gen_mod_sched
  import lock_pkg::*;
#(
  parameter int               HPW     = lock_pkg::HPW,
  parameter int               PHW     = lock_pkg::PHW,
  parameter int               TMO_W   = 28,
  parameter logic [TMO_W-1:0] TIMEOUT = 28'd100_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [HPW-1:0] cfg_hp,
  input  logic [PHW-1:0] cfg_phase,
  input  logic           cfg_wr,
  input  logic           sweep_en,
  input  logic [HPW-1:0] sweep_hp_min,
  input  logic [HPW-1:0] sweep_hp_max,
  input  logic [HPW-1:0] sweep_step,
  input  logic [7:0]     sweep_dwell,
  input  logic           harmonic_trig,
  output logic [HPW-1:0] hp,
  output logic [PHW-1:0] phase,
  output logic           busy,
  output logic           upd_done,
  output logic           sweep_wrap,
  output logic           gen_rst
);

  sched_state_e   state;
  logic [HPW-1:0] stg_hp;
  logic [PHW-1:0] stg_phase;
  logic [7:0]     dwell_cnt;

  // ---------------------------------------------------------------------------
  // Next sweep value. The sum is formed one bit wider so a carry past the top
  // of the hp range still compares as "above max" and wraps.
  // ---------------------------------------------------------------------------
  logic [HPW:0]   sweep_sum;
  logic [HPW-1:0] step_hp;
  logic           step_wrap;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sweep_sum = {1'b0, hp} + {1'b0, sweep_step};
    step_hp   = hp;
    step_wrap = 1'b0;
    if (sweep_hp_min > sweep_hp_max) begin
      // Inverted limits: pin to min and report the wrap on every step.
      step_hp   = sweep_hp_min;
      step_wrap = 1'b1;
    end else if (hp < sweep_hp_min) begin
      // Entered the sweep below range: first step lands on min.
      step_hp = sweep_hp_min;
    end else if (sweep_step == '0) begin
      step_hp = hp;
    end else if (sweep_sum > {1'b0, sweep_hp_max}) begin
      step_hp   = sweep_hp_min;
      step_wrap = 1'b1;
    end else begin
      step_hp = sweep_sum[HPW-1:0];
    end
  end

`ifdef GEN_MOD_SCHED_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LOAD = TIMEOUT - 1'b1;

  logic wdg_expired;
  logic gen_rst_q;

  // Loaded on every cfg_wr (the only way into PEND), so each write restarts
  // the full TIMEOUT window.
  sched_watchdog #(
    .W (TMO_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load     (cfg_wr),
    .load_val (TMO_LOAD),
    .clr      (state != SCHED_PEND),
    .en       (state == SCHED_PEND),
    .expired  (wdg_expired)
  );

  assign gen_rst = gen_rst_q;
`else
  assign gen_rst = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCHED_IDLE;
      stg_hp     <= '0;
      stg_phase  <= '0;
      dwell_cnt  <= '0;
      hp         <= '0;
      phase      <= '0;
      busy       <= 1'b0;
      upd_done   <= 1'b0;
      sweep_wrap <= 1'b0;
`ifdef GEN_MOD_SCHED_TIMEOUT_EN
      gen_rst_q  <= 1'b0;
`endif
    end else begin
      upd_done   <= 1'b0;
      sweep_wrap <= 1'b0;
`ifdef GEN_MOD_SCHED_TIMEOUT_EN
      gen_rst_q  <= 1'b0;
`endif
      unique case (state)
        SCHED_IDLE: begin
          dwell_cnt <= '0;
          if (cfg_wr) begin
            stg_hp    <= cfg_hp;
            stg_phase <= cfg_phase;
            busy      <= 1'b1;
            state     <= SCHED_PEND;
          end else if (sweep_en) begin
            state <= SCHED_SWEEP;
          end
        end

        SCHED_PEND: begin
          dwell_cnt <= '0;
          if (harmonic_trig) begin
            // A write landing on the boundary itself is the freshest value.
            hp       <= cfg_wr ? cfg_hp    : stg_hp;
            phase    <= cfg_wr ? cfg_phase : stg_phase;
            upd_done <= 1'b1;
            busy     <= 1'b0;
            state    <= sweep_en ? SCHED_SWEEP : SCHED_IDLE;
          end else if (cfg_wr) begin
            stg_hp    <= cfg_hp;
            stg_phase <= cfg_phase;
`ifdef GEN_MOD_SCHED_TIMEOUT_EN
          end else if (wdg_expired) begin
            // No boundary arrived: commit anyway and resync the generator.
            hp        <= stg_hp;
            phase     <= stg_phase;
            upd_done  <= 1'b1;
            gen_rst_q <= 1'b1;
            busy      <= 1'b0;
            state     <= sweep_en ? SCHED_SWEEP : SCHED_IDLE;
`endif
          end
        end

        SCHED_SWEEP: begin
          if (cfg_wr) begin
            stg_hp    <= cfg_hp;
            stg_phase <= cfg_phase;
            busy      <= 1'b1;
            dwell_cnt <= '0;
            state     <= SCHED_PEND;
          end else if (!sweep_en) begin
            state <= SCHED_IDLE;
          end else if (harmonic_trig) begin
            // >= rather than == so a dwell reprogrammed below the running
            // count steps at once instead of counting round to 255.
            if (dwell_cnt >= sweep_dwell) begin
              dwell_cnt  <= '0;
              hp         <= step_hp;
              sweep_wrap <= step_wrap;
            end else begin
              dwell_cnt <= dwell_cnt + 8'd1;
            end
          end
        end

        default: state <= SCHED_IDLE;
      endcase
    end
  end

endmodule : gen_mod_sched

// File: tb/tb_gen_mod_sched.sv
// -----------------------------------------------------------------------------
// tb_gen_mod_sched
// Directed self-checking bench for gen_mod_sched. Inputs change and outputs are
// sampled 1 ns after each rising edge. With GEN_MOD_SCHED_TIMEOUT_EN defined
// the watchdog scenario expects a forced commit after TIMEOUT=100 clocks;
// otherwise it expects PEND to wait indefinitely.
// -----------------------------------------------------------------------------
module tb_gen_mod_sched;

  localparam int HPW = 14;
  localparam int PHW = 13;

  logic           clk;
  logic           rst;
  logic [HPW-1:0] cfg_hp;
  logic [PHW-1:0] cfg_phase;
  logic           cfg_wr;
  logic           sweep_en;
  logic [HPW-1:0] sweep_hp_min;
  logic [HPW-1:0] sweep_hp_max;
  logic [HPW-1:0] sweep_step;
  logic [7:0]     sweep_dwell;
  logic           harmonic_trig;
  logic [HPW-1:0] hp;
  logic [PHW-1:0] phase;
  logic           busy;
  logic           upd_done;
  logic           sweep_wrap;
  logic           gen_rst;

  int n_cmp = 0;
  int n_bad = 0;

  gen_mod_sched #(
    .HPW     (HPW),
    .PHW     (PHW),
    .TMO_W   (28),
    .TIMEOUT (28'd100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_hp        (cfg_hp),
    .cfg_phase     (cfg_phase),
    .cfg_wr        (cfg_wr),
    .sweep_en      (sweep_en),
    .sweep_hp_min  (sweep_hp_min),
    .sweep_hp_max  (sweep_hp_max),
    .sweep_step    (sweep_step),
    .sweep_dwell   (sweep_dwell),
    .harmonic_trig (harmonic_trig),
    .hp            (hp),
    .phase         (phase),
    .busy          (busy),
    .upd_done      (upd_done),
    .sweep_wrap    (sweep_wrap),
    .gen_rst       (gen_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; cfg_wr = 1'b0; harmonic_trig = 1'b0; sweep_en = 1'b0;
    cfg_hp = '0; cfg_phase = '0;
    sweep_hp_min = '0; sweep_hp_max = '0; sweep_step = '0; sweep_dwell = '0;
    repeat (3) tick();
    n_cmp++; if (hp !== 14'd0) begin n_bad++; $display("FAIL reset_hp: got %0d expected 0", hp); end
    n_cmp++; if (phase !== 13'd0) begin n_bad++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    n_cmp++; if ({busy, upd_done, sweep_wrap, gen_rst} !== 4'b0000)
      begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, upd_done, sweep_wrap, gen_rst}); end
    rst = 1'b0;
    tick();
    n_cmp++; if ({busy, upd_done} !== 2'b00) begin n_bad++; $display("FAIL reset_release: got %b expected 00", {busy, upd_done}); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_commit();
    bit busy_held = 1'b1;
    bit out_held  = 1'b1;
    cfg_hp = 14'd99; cfg_phase = 13'd200; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL commit_busy_rise: got %b expected 1", busy); end
    repeat (49) begin
      tick();
      if (busy !== 1'b1) busy_held = 1'b0;
      if (hp !== 14'd0 || upd_done !== 1'b0) out_held = 1'b0;
    end
    n_cmp++; if (busy_held !== 1'b1) begin n_bad++; $display("FAIL commit_busy_hold: got %b expected 1", busy_held); end
    n_cmp++; if (out_held !== 1'b1) begin n_bad++; $display("FAIL commit_early: got %b expected 1", out_held); end
    harmonic_trig = 1'b1;
    tick();
    harmonic_trig = 1'b0;
    n_cmp++; if (hp !== 14'd99) begin n_bad++; $display("FAIL commit_hp: got %0d expected 99", hp); end
    n_cmp++; if (phase !== 13'd200) begin n_bad++; $display("FAIL commit_phase: got %0d expected 200", phase); end
    n_cmp++; if (upd_done !== 1'b1) begin n_bad++; $display("FAIL commit_upd_done: got %b expected 1", upd_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL commit_busy_fall: got %b expected 0", busy); end
    tick();
    n_cmp++; if (upd_done !== 1'b0) begin n_bad++; $display("FAIL commit_pulse_width: got %b expected 0", upd_done); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overwrite();
    int dones = 0;
    cfg_hp = 14'd10; cfg_phase = 13'd5; cfg_wr = 1'b1;
    tick(); dones += int'(upd_done);
    cfg_hp = 14'd20; cfg_phase = 13'd6;
    tick(); dones += int'(upd_done);
    cfg_wr = 1'b0;
    repeat (2) begin tick(); dones += int'(upd_done); end
    harmonic_trig = 1'b1;
    tick(); dones += int'(upd_done);
    harmonic_trig = 1'b0;
    repeat (3) begin tick(); dones += int'(upd_done); end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL overwrite_done_count: got %0d expected 1", dones); end
    n_cmp++; if (hp !== 14'd20) begin n_bad++; $display("FAIL overwrite_hp: got %0d expected 20", hp); end
    n_cmp++; if (phase !== 13'd6) begin n_bad++; $display("FAIL overwrite_phase: got %0d expected 6", phase); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    cfg_hp = 14'd30; cfg_phase = 13'd3; cfg_wr = 1'b1;
    tick();
    cfg_hp = 14'd7; cfg_phase = 13'd9; harmonic_trig = 1'b1;
    tick();
    cfg_wr = 1'b0; harmonic_trig = 1'b0;
    n_cmp++; if (hp !== 14'd7) begin n_bad++; $display("FAIL simul_hp: got %0d expected 7", hp); end
    n_cmp++; if (phase !== 13'd9) begin n_bad++; $display("FAIL simul_phase: got %0d expected 9", phase); end
    n_cmp++; if ({upd_done, busy} !== 2'b10) begin n_bad++; $display("FAIL simul_flags: got %b expected 10", {upd_done, busy}); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL simul_no_repend: got %b expected 0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sweep();
    int exp_hp  [8] = '{0, 4, 4, 7, 7, 10, 10, 4};
    bit exp_wrap[8] = '{0, 0, 0, 0, 0, 0,  0,  1};
    int wraps = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    sweep_hp_min = 14'd4; sweep_hp_max = 14'd10; sweep_step = 14'd3; sweep_dwell = 8'd1;
    sweep_en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      harmonic_trig = 1'b1;
      tick();
      harmonic_trig = 1'b0;
      wraps += int'(sweep_wrap);
      n_cmp++; if (hp !== exp_hp[i][HPW-1:0])
        begin n_bad++; $display("FAIL sweep_hp[%0d]: got %0d expected %0d", i, hp, exp_hp[i]); end
      n_cmp++; if (sweep_wrap !== exp_wrap[i])
        begin n_bad++; $display("FAIL sweep_wrap[%0d]: got %b expected %b", i, sweep_wrap, exp_wrap[i]); end
      tick();
      wraps += int'(sweep_wrap);
    end
    n_cmp++; if (wraps !== 1) begin n_bad++; $display("FAIL sweep_wrap_count: got %0d expected 1", wraps); end
    sweep_en = 1'b0;
    tick();
    repeat (3) begin harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0; tick(); end
    n_cmp++; if (hp !== 14'd4) begin n_bad++; $display("FAIL sweep_hold_on_exit: got %0d expected 4", hp); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sweep_edges();
    sweep_hp_min = 14'd4; sweep_hp_max = 14'd10; sweep_step = 14'd0; sweep_dwell = 8'd0;
    sweep_en = 1'b1;
    tick();
    harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0;
    n_cmp++; if ({hp, sweep_wrap} !== {14'd4, 1'b0})
      begin n_bad++; $display("FAIL step0_hold: got hp=%0d wrap=%b expected hp=4 wrap=0", hp, sweep_wrap); end
    sweep_hp_min = 14'd12;
    harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0;
    n_cmp++; if ({hp, sweep_wrap} !== {14'd12, 1'b1})
      begin n_bad++; $display("FAIL inverted_limits: got hp=%0d wrap=%b expected hp=12 wrap=1", hp, sweep_wrap); end
    // A write beats a step arriving in the same cycle.
    cfg_hp = 14'd50; cfg_phase = 13'd1; cfg_wr = 1'b1; harmonic_trig = 1'b1;
    tick();
    cfg_wr = 1'b0; harmonic_trig = 1'b0;
    n_cmp++; if ({busy, upd_done, sweep_wrap, hp} !== {3'b100, 14'd12})
      begin n_bad++; $display("FAIL sweep_wr_priority: got busy=%b done=%b wrap=%b hp=%0d expected 1 0 0 12", busy, upd_done, sweep_wrap, hp); end
    harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0;
    n_cmp++; if ({hp, upd_done, busy} !== {14'd50, 2'b10})
      begin n_bad++; $display("FAIL sweep_commit: got hp=%0d done=%b busy=%b expected 50 1 0", hp, upd_done, busy); end
    tick();
    harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0;
    n_cmp++; if ({hp, sweep_wrap} !== {14'd12, 1'b1})
      begin n_bad++; $display("FAIL sweep_resume: got hp=%0d wrap=%b expected hp=12 wrap=1", hp, sweep_wrap); end
    sweep_en = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_watchdog();
    int dones = 0;
    int resyncs = 0;
    int first = -1;
    logic           gr_at_first = 1'b0;
    logic [HPW-1:0] hp_at_first = '0;
    cfg_hp = 14'd123; cfg_phase = 13'd45; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
`ifdef GEN_MOD_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 130; k++) begin
      tick();
      dones   += int'(upd_done);
      resyncs += int'(gen_rst);
      if (upd_done === 1'b1 && first < 0) begin
        first = k; gr_at_first = gen_rst; hp_at_first = hp;
      end
    end
    n_cmp++; if (first !== 100) begin n_bad++; $display("FAIL wdg_expiry_clock: got %0d expected 100", first); end
    n_cmp++; if (gr_at_first !== 1'b1) begin n_bad++; $display("FAIL wdg_gen_rst: got %b expected 1", gr_at_first); end
    n_cmp++; if (hp_at_first !== 14'd123) begin n_bad++; $display("FAIL wdg_hp: got %0d expected 123", hp_at_first); end
    n_cmp++; if ({dones, resyncs} !== {32'd1, 32'd1})
      begin n_bad++; $display("FAIL wdg_pulse_count: got done=%0d rst=%0d expected 1 1", dones, resyncs); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wdg_busy: got %b expected 0", busy); end
`else
    for (int k = 1; k <= 150; k++) begin
      tick();
      dones   += int'(upd_done);
      resyncs += int'(gen_rst);
    end
    n_cmp++; if ({dones, resyncs} !== {32'd0, 32'd0})
      begin n_bad++; $display("FAIL nowdg_pulses: got done=%0d rst=%0d expected 0 0", dones, resyncs); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nowdg_busy: got %b expected 1", busy); end
    harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0;
    n_cmp++; if ({hp, upd_done} !== {14'd123, 1'b1})
      begin n_bad++; $display("FAIL nowdg_commit: got hp=%0d done=%b expected 123 1", hp, upd_done); end
`endif
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_pend();
    int dones = 0;
    cfg_hp = 14'd77; cfg_phase = 13'd8; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pending: got %b expected 1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if ({hp, phase, busy, upd_done} !== {14'd0, 13'd0, 2'b00})
      begin n_bad++; $display("FAIL midrst_state: got hp=%0d phase=%0d busy=%b done=%b expected 0 0 0 0", hp, phase, busy, upd_done); end
    repeat (3) begin
      harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0; dones += int'(upd_done);
      tick(); dones += int'(upd_done);
    end
    n_cmp++; if ({dones, 18'(hp)} !== {32'd0, 18'd0})
      begin n_bad++; $display("FAIL midrst_no_commit: got done=%0d hp=%0d expected 0 0", dones, hp); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_commit();
    test_overwrite();
    test_simultaneous();
    test_sweep();
    test_sweep_edges();
    test_watchdog();
    test_reset_mid_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish within 1 ms");
    $fatal(1, "bench timed out");
  end

endmodule : tb_gen_mod_sched

// File: doc/gen_mod_sched.md
# gen_mod_sched

Update scheduler and sweep sequencer for the harmonic modulation generator. It stages the modulation period divider (`hp`) and phase offset (`phase`) written from the register bus and commits them only on a waveform period boundary (`harmonic_trig`), so the reference and harmonic outputs never glitch mid-cycle. In sweep mode it steps `hp` autonomously between programmed limits, one step every N modulation periods. It sits between the lock-in register bank and the generator's `hp`/`phase` inputs.

## Interface
- `HPW`, 14: width of `hp`.
- `PHW`, 13: width of `phase`.
- `TMO_W`, 28: width of the watchdog counter.
- `TIMEOUT`, 28'd100_000_000: clocks to wait for `harmonic_trig` before a forced commit.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_hp`  in  HPW  staged divider value.
- `cfg_phase`  in  PHW  staged phase value.
- `cfg_wr`  in  1  single-cycle strobe; capture `cfg_hp`/`cfg_phase`.
- `sweep_en`  in  1  enable autonomous `hp` sweep.
- `sweep_hp_min`, `sweep_hp_max`  in  HPW  sweep limits, inclusive.
- `sweep_step`  in  HPW  increment per step.
- `sweep_dwell`  in  8  periods per step minus 1.
- `harmonic_trig`  in  1  period-boundary pulse from the generator.
- `hp`  out  HPW  committed divider, registered.
- `phase`  out  PHW  committed phase, registered.
- `busy`  out  1  staged update pending.
- `upd_done`  out  1  one-cycle pulse on each commit.
- `sweep_wrap`  out  1  one-cycle pulse when the sweep wraps to `sweep_hp_min`.
- `gen_rst`  out  1  one-cycle resync pulse to the generator on a forced commit.

## Operation
- FSM states: IDLE, PEND, SWEEP.
- **Reset.** `hp`=0, `phase`=0, `busy`=0, all pulses 0, dwell counter 0, watchdog 0, state IDLE.
- **IDLE.**
  - On `cfg_wr`: capture the staging registers, go to PEND, `busy`=1.
  - Else if `sweep_en`: go to SWEEP.
- **PEND.**
  - On `harmonic_trig`: load `hp`/`phase` from staging, pulse `upd_done`, `busy`=0, then go to SWEEP if `sweep_en`, else IDLE.
  - `cfg_wr` while in PEND: overwrite staging and restart the watchdog.
  - `cfg_wr` and `harmonic_trig` in the same cycle: commit the newly written values directly.
- **SWEEP.**
  - Count `harmonic_trig` pulses. When the count equals `sweep_dwell`, clear the count and step `hp`.
  - Next `hp` is computed in HPW+1 bits as `hp + sweep_step`. If the sum exceeds `sweep_hp_max`, `hp` becomes `sweep_hp_min` and `sweep_wrap` pulses.
  - If `hp` is below `sweep_hp_min` when SWEEP is entered, the first step loads `sweep_hp_min`.
  - `cfg_wr` has priority over a step: go to PEND and clear the dwell count.
  - When `sweep_en` deasserts: return to IDLE and `hp` holds its value.
- `sweep_step`=0: `hp` holds; no wrap is reported.
- `sweep_hp_min` > `sweep_hp_max`: every step loads `sweep_hp_min` and pulses `sweep_wrap`.

## Timing
- Commit latency: `hp`/`phase` and `upd_done` are valid on the clock edge after the `harmonic_trig` cycle, which is 1 cycle of latency.
- `busy` rises on the edge after `cfg_wr` and falls together with the commit.
- A sweep step appears 1 cycle after the qualifying trig.
- `rst` asserted mid-PEND: the staged value is discarded and no `upd_done` is issued.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `GEN_MOD_SCHED_TIMEOUT_EN` defined:
  - In PEND, a watchdog counts clocks.
  - When it reaches `TIMEOUT` with no trig: force the commit, pulse `upd_done` and `gen_rst` in the same cycle, and leave PEND.
  - The watchdog clears on entering PEND and on every `cfg_wr`.
- Undefined: PEND waits indefinitely for `harmonic_trig`, `gen_rst` is tied to 0, and no watchdog logic is built.

## Structure
- Shared package `lock_pkg` holds:
  - the FSM state enum (`SCHED_IDLE`, `SCHED_PEND`, `SCHED_SWEEP`);
  - the `HPW`/`PHW` width constants shared with the generator.
- One sub-module: `sched_watchdog`, a loadable down-counter with clear and an expiry pulse. It is instantiated only under `GEN_MOD_SCHED_TIMEOUT_EN`.

## Test plan
- **Reset and commit.** Reset, then `cfg_wr` with `hp`=99, `phase`=200, then trig after 50 clocks.
  - `busy`=1 from cycle 1 until the commit.
  - `hp`=99, `phase`=200 and `upd_done` appear 1 cycle after the trig.
- **Overwrite while pending.** `cfg_wr` `hp`=10, then `cfg_wr` `hp`=20 before any trig, then trig.
  - Exactly one `upd_done`; `hp`=20.
- **Simultaneous write and trig.** In PEND, `cfg_wr` `hp`=7 in the same cycle as trig.
  - `hp`=7 is committed next cycle.
- **Sweep wrap.** Settings: `sweep_en`=1, min=4, max=10, step=3, dwell=1; 8 trigs.
  - `hp` sequence 4, 7, 10, 4, …; `sweep_wrap` pulses when 10→4.
- **Watchdog.** With `GEN_MOD_SCHED_TIMEOUT_EN` and `TIMEOUT`=100: `cfg_wr`, no trig.
  - `upd_done` and `gen_rst` pulse at clock 100 after entering PEND.
- **Reset mid-pending.** `rst` asserted in PEND.
  - `hp`=0, `busy`=0, no `upd_done` on subsequent trigs.
